// File: rtl/serial_byte_collector_if.sv
// serial_byte_collector_if: serial-in / byte-out bus between feeder logic and the collector
interface serial_byte_collector_if;
  logic ser_in;
  logic ser_valid;
  logic ack;
  logic abort;
  logic clr_flags;
  logic [7:0] data;
  logic [2:0] sel;
  logic byte_valid;
  logic [2:0] bit_cnt;
  logic overrun;
  logic frame_err;
  modport master (
    output ser_in, ser_valid, ack, abort, clr_flags,
    input  data, sel, byte_valid, bit_cnt, overrun, frame_err
  );
  modport slave (
    input  ser_in, ser_valid, ack, abort, clr_flags,
    output data, sel, byte_valid, bit_cnt, overrun, frame_err
  );
endinterface

// File: rtl/serial_byte_collector.sv
// serial_byte_collector: assembles strobed serial bits into a byte and opens the AND gate only while a full byte is held
module serial_byte_collector #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input logic clk,
  input logic rst,
  serial_byte_collector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state, state_n;
  logic [7:0] data, data_n, idle, idle_n, shifted, first;
  logic [2:0] cnt, cnt_n;
  logic ovr, ovr_n, ferr, ferr_n, timeout;
  assign shifted = LSB_FIRST ? {bus.ser_in, data[7:1]} : {data[6:0], bus.ser_in};
  assign first   = LSB_FIRST ? {bus.ser_in, 7'b0} : {7'b0, bus.ser_in};
  assign timeout = (TO != 8'd0) && (idle + 8'd1 == TO);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      idle  <= '0;
      cnt   <= '0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      data  <= data_n;
      idle  <= idle_n;
      cnt   <= cnt_n;
      ovr   <= ovr_n;
      ferr  <= ferr_n;
    end
  end
  // A new overrun in the same edge as clr_flags must win, so it is applied after the clear
  always_comb begin
    state_n = state;
    data_n  = data;
    idle_n  = idle;
    cnt_n   = cnt;
    ferr_n  = 1'b0;
    ovr_n   = bus.clr_flags ? 1'b0 : ovr;
    if (bus.abort) begin
      state_n = IDLE;
      data_n  = '0;
      idle_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (bus.ser_valid) begin
          state_n = SHIFT;
          data_n  = first;
          cnt_n   = 3'd1;
          idle_n  = '0;
        end
        SHIFT: if (bus.ser_valid) begin
          data_n  = shifted;
          cnt_n   = cnt + 3'd1;
          idle_n  = '0;
          state_n = (cnt == 3'd7) ? HOLD : SHIFT;
        end else if (timeout) begin
          state_n = IDLE;
          data_n  = '0;
          cnt_n   = '0;
          idle_n  = '0;
          ferr_n  = 1'b1;
        end else begin
          idle_n  = idle + 8'd1;
        end
        default: if (bus.ack) begin
          state_n = bus.ser_valid ? SHIFT : IDLE;
          data_n  = bus.ser_valid ? first : 8'h00;
          cnt_n   = bus.ser_valid ? 3'd1 : 3'd0;
        end else if (bus.ser_valid) begin
          ovr_n   = 1'b1;
        end
      endcase
    end
  end
  always_comb begin
    bus.data       = data;
    bus.sel        = (state == HOLD) ? 3'b111 : 3'b000;
    bus.byte_valid = (state == HOLD);
    bus.bit_cnt    = cnt;
    bus.overrun    = ovr;
    bus.frame_err  = ferr;
  end
endmodule

// File: tb/tb_serial_byte_collector.sv
// tb_serial_byte_collector: vector table, corner sequences and random traffic against a bit-list reference model
module tb_serial_byte_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_byte_collector_if b0();
  serial_byte_collector_if b1();
  serial_byte_collector #(.LSB_FIRST(1'b1), .TIMEOUT(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  serial_byte_collector #(.LSB_FIRST(1'b0), .TIMEOUT(5))  dut1 (.clk(clk), .rst(rst), .bus(b1));
  assign b1.ser_in    = b0.ser_in;
  assign b1.ser_valid = b0.ser_valid;
  assign b1.ack       = b0.ack;
  assign b1.abort     = b0.abort;
  assign b1.clr_flags = b0.clr_flags;
  typedef struct packed {
    logic [5:0]  in;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[19];
  int checks = 0;
  int fails = 0;
  int n[2];
  int idle[2];
  bit hold[2];
  bit ovr[2];
  bit ferr[2];
  logic [7:0] ord[2];
  function automatic vec_t v(logic [5:0] in, logic [7:0] d, logic bv, logic [2:0] c, logic o);
    return {in, d, bv ? 3'b111 : 3'b000, bv, c, o, 1'b0};
  endfunction
  // Expected outputs: the n received bits laid out by arrival order, never a shift register
  function automatic logic [16:0] expv(int k);
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < n[k]; i++) d[k == 0 ? 8 - n[k] + i : n[k] - 1 - i] = ord[k][i];
    return {d, hold[k] ? 3'b111 : 3'b000, hold[k], hold[k] ? 3'd0 : 3'(n[k]), ovr[k], ferr[k]};
  endfunction
  task automatic model_step(int k, logic sv, logic si, logic ack, logic ab, logic clr, logic r);
    int to;
    to = (k == 0) ? 16 : 5;
    ferr[k] = 1'b0;
    if (r) begin
      n[k] = 0; hold[k] = 1'b0; idle[k] = 0; ovr[k] = 1'b0;
    end else begin
      if (clr) ovr[k] = 1'b0;
      if (ab) begin
        n[k] = 0; hold[k] = 1'b0; idle[k] = 0;
      end else if (hold[k]) begin
        if (ack) begin
          hold[k] = 1'b0; n[k] = sv ? 1 : 0; ord[k][0] = si;
        end else if (sv) ovr[k] = 1'b1;
      end else if (sv) begin
        ord[k][n[k]] = si; n[k] = n[k] + 1; idle[k] = 0;
        if (n[k] == 8) hold[k] = 1'b1;
      end else if (n[k] > 0) begin
        idle[k] = idle[k] + 1;
        if (idle[k] == to) begin
          n[k] = 0; idle[k] = 0; ferr[k] = 1'b1;
        end
      end
    end
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [16:0] pack0();
    return {b0.data, b0.sel, b0.byte_valid, b0.bit_cnt, b0.overrun, b0.frame_err};
  endfunction
  function automatic logic [16:0] pack1();
    return {b1.data, b1.sel, b1.byte_valid, b1.bit_cnt, b1.overrun, b1.frame_err};
  endfunction
  task automatic cycle(logic sv, logic si, logic ack, logic ab, logic clr, logic r);
    b0.ser_valid = sv; b0.ser_in = si; b0.ack = ack; b0.abort = ab; b0.clr_flags = clr; rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, sv, si, ack, ab, clr, r);
    #1;
    check("model_lsb", 32'(pack0()), 32'(expv(0)));
    check("model_msb", 32'(pack1()), 32'(expv(1)));
    @(negedge clk);
  endtask
  initial begin
    int pulses, at;
    logic [7:0] byte_val;
    b0.ser_valid = 1'b0; b0.ser_in = 1'b0; b0.ack = 1'b0; b0.abort = 1'b0; b0.clr_flags = 1'b0;
    // inputs {ser_valid, ser_in, ack, abort, clr_flags, rst}
    tbl[0]  = v(6'b000001, 8'h00, 0, 0, 0);
    tbl[1]  = v(6'b000001, 8'h00, 0, 0, 0);
    tbl[2]  = v(6'b110000, 8'h80, 0, 1, 0);
    tbl[3]  = v(6'b100000, 8'h40, 0, 2, 0);
    tbl[4]  = v(6'b110000, 8'hA0, 0, 3, 0);
    tbl[5]  = v(6'b100000, 8'h50, 0, 4, 0);
    tbl[6]  = v(6'b100000, 8'h28, 0, 5, 0);
    tbl[7]  = v(6'b110000, 8'h94, 0, 6, 0);
    tbl[8]  = v(6'b100000, 8'h4A, 0, 7, 0);
    tbl[9]  = v(6'b110000, 8'hA5, 1, 0, 0);
    tbl[10] = v(6'b110000, 8'hA5, 1, 0, 1);
    tbl[11] = v(6'b000010, 8'hA5, 1, 0, 0);
    tbl[12] = v(6'b100010, 8'hA5, 1, 0, 1);
    tbl[13] = v(6'b111000, 8'h80, 0, 1, 1);
    tbl[14] = v(6'b100110, 8'h00, 0, 0, 0);
    tbl[15] = v(6'b000000, 8'h00, 0, 0, 0);
    tbl[16] = v(6'b001000, 8'h00, 0, 0, 0);
    tbl[17] = v(6'b110000, 8'h80, 0, 1, 0);
    tbl[18] = v(6'b000001, 8'h00, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("vec%0d", i), 32'(pack0()), 32'(tbl[i].exp));
    end
    // Timeout: three bits, then idle; the pulse must land on the 16th idle edge only
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    pulses = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (b0.frame_err) begin pulses++; at = i; end
    end
    check("t5_pulses", 32'(pulses), 32'd1);
    check("t5_at", 32'(at), 32'd16);
    byte_val = 8'h1B;
    for (int i = 0; i < 8; i++) cycle(1, byte_val[i], 0, 0, 0, 0);
    check("t5_byte", {23'd0, b0.data, b0.byte_valid}, {23'd0, 8'h1B, 1'b1});
    check("t5_byte_msb", {24'd0, b1.data}, 32'hD8);
    cycle(1, 1, 0, 1, 0, 0);
    check("t6_abort", {22'd0, b0.data, b0.byte_valid, b0.frame_err}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("t6_rst", {20'd0, b0.data, b0.bit_cnt, b0.frame_err}, 32'd0);
    for (int blk = 0; blk < 60; blk++) begin
      int p;
      p = (blk % 3 == 0) ? 2 : (blk % 3 == 1) ? 8 : 22;
      for (int c = 0; c < 64; c++)
        cycle($urandom_range(p - 1) == 0, 1'($urandom_range(1)), $urandom_range(3) == 0,
              $urandom_range(40) == 0, $urandom_range(15) == 0, $urandom_range(200) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
